// File: rtl/rsensor.sv
// Ultrasonic range sensor model: accepts a debounced trigger and returns an echo pulse whose width encodes distance.
// Latency: trigger rise to echo rise = 2 + TRIG_MIN_CYCLES + ECHO_DELAY_CYCLES cycles (+/-1 for async alignment).
// Backpressure: none; triggers arriving outside IDLE/ARM are dropped, never queued.
//
// Ports:
//    clk      - single clock, rising edge
//    rst      - synchronous active-high reset; aborts any measurement in progress
//    in_trig  - asynchronous trigger request (must be seen low before it can fire again)
//    out_echo - registered echo pulse, width = DIST_CM*CYCLES_PER_CM (or TIMEOUT_CYCLES if out of range)
//    out_busy - high whenever the FSM is not IDLE
//
// All cycle-count parameters are expected to be >= 1; a value of 0 behaves like 1.

module rsensor #(
   parameter int TRIG_MIN_CYCLES   = 10,
   parameter int ECHO_DELAY_CYCLES = 20,
   parameter int CYCLES_PER_CM     = 4,
   parameter int DIST_CM           = 25,
   parameter int MIN_CM            = 2,
   parameter int MAX_CM            = 400,
   parameter int TIMEOUT_CYCLES    = 2000,
   parameter int COOLDOWN_CYCLES   = 50
) (
   input  logic clk,
   input  logic rst,
   input  logic in_trig,
   output logic out_echo,
   output logic out_busy
);

   // Echo width is fixed at elaboration: in-range targets scale with distance,
   // anything outside the valid window reports the timeout width.
   localparam logic [31:0] ECHO_W =
      ((DIST_CM >= MIN_CM) && (DIST_CM <= MAX_CM)) ? 32'(DIST_CM * CYCLES_PER_CM)
                                                   : 32'(TIMEOUT_CYCLES);
   localparam logic [31:0] TRIG_N = 32'(TRIG_MIN_CYCLES);
   localparam logic [31:0] DLY_N  = 32'(ECHO_DELAY_CYCLES);
   localparam logic [31:0] COOL_N = 32'(COOLDOWN_CYCLES);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ARM      = 3'd1;
   localparam logic [2:0] S_DELAY    = 3'd2;
   localparam logic [2:0] S_ECHO     = 3'd3;
   localparam logic [2:0] S_COOLDOWN = 3'd4;

   logic        trig_m;     // first synchronizer stage (may go metastable)
   logic        trig_s;     // synchronized trigger
   logic        trig_prev;  // trig_s from the previous cycle, for edge detection
   logic [1:0]  fill;       // marks when trig_s carries real post-reset samples
   logic [2:0]  state;
   logic [31:0] cnt;
   logic        trig_rise;

   // The synchronizer flops reset to 0, which would look like a low phase of
   // in_trig. Edge detection (and the history register) is held off until
   // two real samples have passed through, so a trigger held high across
   // reset must genuinely go low before it can fire.
   assign trig_rise = fill[1] & trig_s & ~trig_prev;

   assign out_busy = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         trig_m    <= 1'b0;
         trig_s    <= 1'b0;
         fill      <= 2'b00;
         trig_prev <= 1'b1;
         state     <= S_IDLE;
         cnt       <= 32'd0;
         out_echo  <= 1'b0;
      end else begin
         trig_m <= in_trig;
         trig_s <= trig_m;
         fill   <= {fill[0], 1'b1};
         if (fill[1]) begin
            trig_prev <= trig_s;
         end

         case (state)
            S_IDLE: begin
               out_echo <= 1'b0;
               cnt      <= 32'd0;
               if (trig_rise) begin
                  // The rising-edge cycle itself is the first high cycle.
                  cnt   <= 32'd1;
                  state <= (TRIG_N <= 32'd1) ? S_DELAY : S_ARM;
               end
            end

            S_ARM: begin
               if (!trig_s) begin
                  // Trigger released before qualifying: glitch, no echo.
                  state <= S_IDLE;
                  cnt   <= 32'd0;
               end else if ((cnt + 32'd1) >= TRIG_N) begin
                  state <= S_DELAY;
                  cnt   <= 32'd1;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            S_DELAY: begin
               if (cnt >= DLY_N) begin
                  // Raise the echo on the same edge that enters ECHO so the
                  // pulse occupies exactly the ECHO-state cycles.
                  state    <= S_ECHO;
                  cnt      <= 32'd1;
                  out_echo <= 1'b1;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            S_ECHO: begin
               if (cnt >= ECHO_W) begin
                  state    <= S_COOLDOWN;
                  cnt      <= 32'd1;
                  out_echo <= 1'b0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            S_COOLDOWN: begin
               out_echo <= 1'b0;
               if (cnt >= COOL_N) begin
                  state <= S_IDLE;
                  cnt   <= 32'd0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            default: begin
               state    <= S_IDLE;
               cnt      <= 32'd0;
               out_echo <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rsensor.sv
// Bench for rsensor: three instances (default, far out-of-range, near out-of-range).
// Latency: n/a. Backpressure: n/a.
// Stimulus pushes expected echo pulses; a negedge monitor measures every pulse and cooldown.

module tb_rsensor;

   logic clk = 1'b0;
   logic rst0, rst12;
   logic trig0, trig12;
   logic echo0, echo1, echo2;
   logic busy0, busy1, busy2;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      int dut;
      int rise;
      int width;
   } exp_t;

   exp_t q[$];

   bit in_pulse [3];
   bit in_cool  [3];
   int rise_c   [3];
   int wid      [3];
   int coolcnt  [3];
   int ecnt     [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rsensor u0 (.clk(clk), .rst(rst0), .in_trig(trig0), .out_echo(echo0), .out_busy(busy0));

   rsensor #(.DIST_CM(500)) u1 (.clk(clk), .rst(rst12), .in_trig(trig12), .out_echo(echo1), .out_busy(busy1));

   rsensor #(.DIST_CM(1)) u2 (.clk(clk), .rst(rst12), .in_trig(trig12), .out_echo(echo2), .out_busy(busy2));

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_lat(input string nm, input int act, input int exp);
      tests++;
      if ((act < exp - 1) || (act > exp + 1)) begin
         fails++;
         $display("FAIL %s: rise at cycle %0d, expected %0d +/-1", nm, act, exp);
      end
   endtask

   function automatic int find_exp(input int d);
      for (int k = 0; k < q.size(); k++) begin
         if (q[k].dut == d) return k;
      end
      return -1;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_echo(input int d, input int w);
      exp_t e;
      e.dut   = d;
      e.rise  = cyc + 32;
      e.width = w;
      q.push_back(e);
   endtask

   // Monitor: measures every echo pulse and the busy tail that follows it.
   always @(negedge clk) begin : mon
      logic [2:0] ev, bv, rv;
      int k;
      ev = {echo2, echo1, echo0};
      bv = {busy2, busy1, busy0};
      rv = {rst12, rst12, rst0};
      for (int i = 0; i < 3; i++) begin
         if (rv[i]) begin
            // A reset aborts the pulse; its expectation is retired unmeasured.
            if (in_pulse[i]) begin
               k = find_exp(i);
               if (k >= 0) q.delete(k);
            end
            in_pulse[i] = 1'b0;
            in_cool[i]  = 1'b0;
         end else if (ev[i] && !in_pulse[i]) begin
            in_pulse[i] = 1'b1;
            in_cool[i]  = 1'b0;
            rise_c[i]   = cyc;
            wid[i]      = 1;
            ecnt[i]++;
         end else if (ev[i]) begin
            wid[i]++;
         end else if (in_pulse[i]) begin
            in_pulse[i] = 1'b0;
            k = find_exp(i);
            if (k < 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_echo dut%0d: width %0d, no pulse was expected", i, wid[i]);
            end else begin
               chk_lat($sformatf("latency_dut%0d", i), rise_c[i], q[k].rise);
               chk($sformatf("width_dut%0d", i), wid[i], q[k].width);
               q.delete(k);
            end
            in_cool[i] = 1'b1;
            coolcnt[i] = bv[i] ? 1 : 0;
         end else if (in_cool[i]) begin
            if (bv[i]) begin
               coolcnt[i]++;
            end else begin
               chk($sformatf("cooldown_dut%0d", i), coolcnt[i], 50);
               in_cool[i] = 1'b0;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin
      trig0  = 1'b0;
      trig12 = 1'b0;
      rst0   = 1'b1;
      rst12  = 1'b1;
      tick(3);
      chk("reset_echo0", int'(echo0), 0);
      chk("reset_busy0", int'(busy0), 0);
      chk("reset_echo1", int'(echo1), 0);
      chk("reset_busy2", int'(busy2), 0);
      rst0  = 1'b0;
      rst12 = 1'b0;
      tick(5);

      // Basic measurement on all three instances; trig held high afterwards.
      trig0 = 1'b1;
      expect_echo(0, 100);
      trig12 = 1'b1;
      expect_echo(1, 2000);
      expect_echo(2, 2000);
      tick(40);
      chk("busy_during_echo", int'(busy0), 1);
      tick(160);
      chk("idle_after_first", int'(busy0), 0);
      tick(100);
      chk("held_high_no_refire", ecnt[0], 1);
      chk("held_high_idle", int'(busy0), 0);

      // Low then high again fires a second identical echo.
      trig0 = 1'b0;
      tick(5);
      trig0 = 1'b1;
      expect_echo(0, 100);
      tick(200);
      chk("second_echo_count", ecnt[0], 2);
      chk("second_echo_idle", int'(busy0), 0);

      // Short 5-cycle trigger: arms, then falls back to IDLE without echo.
      trig0 = 1'b0;
      tick(5);
      trig0 = 1'b1;
      tick(3);
      chk("short_trig_armed", int'(busy0), 1);
      tick(2);
      trig0 = 1'b0;
      tick(10);
      chk("short_trig_idle", int'(busy0), 0);
      chk("short_trig_no_echo", ecnt[0], 2);

      // Toggle trigger through DELAY/ECHO/COOLDOWN: width unchanged, no extra echo.
      trig0 = 1'b1;
      expect_echo(0, 100);
      tick(12);
      for (int j = 0; j < 27; j++) begin
         trig0 = ~trig0;
         tick(6);
      end
      tick(30);
      chk("toggle_echo_count", ecnt[0], 3);
      chk("toggle_idle", int'(busy0), 0);

      // Reset during ECHO aborts the pulse; held trigger must not fire after release.
      trig0 = 1'b1;
      expect_echo(0, 100);
      tick(60);
      chk("echo_before_reset", int'(echo0), 1);
      rst0 = 1'b1;
      tick(1);
      chk("reset_abort_echo", int'(echo0), 0);
      chk("reset_abort_busy", int'(busy0), 0);
      rst0 = 1'b0;
      tick(100);
      chk("post_reset_held_no_echo", ecnt[0], 4);
      chk("post_reset_held_idle", int'(busy0), 0);
      trig0 = 1'b0;
      tick(5);
      trig0 = 1'b1;
      expect_echo(0, 100);
      tick(200);
      chk("post_reset_retrigger", ecnt[0], 5);

      // Let the out-of-range instances finish their timeout-width pulses.
      for (int n = 0; n < 4000 && (q.size() != 0 || busy1 || busy2); n++) tick(1);
      tick(2);
      chk("pending_expectations", q.size(), 0);
      chk("far_echo_count", ecnt[1], 1);
      chk("near_echo_count", ecnt[2], 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rsensor.md
RSENSOR -- requirements
Module: rsensor

Interface
REQ-001 Parameter TRIG_MIN_CYCLES, default 10: minimum consecutive high cycles of the synchronized trigger needed to accept a trigger.
REQ-002 Parameter ECHO_DELAY_CYCLES, default 20: cycles from trigger acceptance to echo rise (models the burst time).
REQ-003 Parameter CYCLES_PER_CM, default 4: echo-high cycles per centimetre of simulated distance.
REQ-004 Parameter DIST_CM, default 25: simulated target distance in cm.
REQ-005 Parameter MIN_CM / MAX_CM, defaults 2 / 400: valid range limits.
REQ-006 Parameter TIMEOUT_CYCLES, default 2000: echo width for an out-of-range target.
REQ-007 Parameter COOLDOWN_CYCLES, default 50: dead time after echo fall.
REQ-008 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-009 Port rst, input, 1: reset is synchronous and active-high.
REQ-010 Port in_trig, input, 1: asynchronous trigger request.
REQ-011 Port out_echo, output, 1: registered echo pulse; its width encodes distance.
REQ-012 Port out_busy, output, 1: high in every state except IDLE.

Function
REQ-013 in_trig SHALL pass through a 2-flop synchronizer (trig_s) before any use; X on in_trig before first drive SHALL NOT propagate past the synchronizer after reset.
REQ-014 A rising edge SHALL be trig_s==1 while the previous sampled trig_s==0.
REQ-015 FSM states SHALL be IDLE, ARM, DELAY, ECHO, COOLDOWN.
REQ-016 IDLE->ARM on a rising edge; the ARM counter starts at 1 on that cycle.
REQ-017 ARM: count consecutive trig_s==1 cycles; at count==TRIG_MIN_CYCLES go to DELAY; trig_s==0 first -> IDLE, with no echo.
REQ-018 DELAY SHALL last exactly ECHO_DELAY_CYCLES cycles, then go to ECHO.
REQ-019 ECHO: out_echo=1 for exactly W cycles, then out_echo=0 and go to COOLDOWN.
REQ-020 W=DIST_CM*CYCLES_PER_CM when MIN_CM<=DIST_CM<=MAX_CM, otherwise W=TIMEOUT_CYCLES.
REQ-021 W SHALL be computed at elaboration with a 32-bit counter; no overflow for legal parameters.
REQ-022 COOLDOWN SHALL last COOLDOWN_CYCLES cycles, then go to IDLE.
REQ-023 Trigger edges and levels outside IDLE/ARM SHALL be ignored and not queued.
REQ-024 in_trig held high through the end of COOLDOWN SHALL NOT re-fire; in_trig must go low and then high again.
REQ-025 out_echo SHALL be driven only from a flop and SHALL be glitch-free.
REQ-026 Latency: rising edge on in_trig to out_echo rise = 2 (sync) + TRIG_MIN_CYCLES + ECHO_DELAY_CYCLES cycles, ±1 cycle for asynchronous input alignment.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, all counters=0, out_echo=0, out_busy=0, synchronizer flops=0.
REQ-028 After reset, the previous-trigger register SHALL be 1, so a trigger held high across reset does not fire until it has been seen low.
REQ-029 rst mid-operation (any state) SHALL abort immediately; out_echo SHALL be 0 on the next cycle.

Verification
REQ-030 Defaults; in_trig 0 then 1 (held high) -> out_echo rises about 32 cycles later, stays high for exactly 100 cycles, and out_busy stays high until 50 cycles after the fall.
REQ-031 After the echo and cooldown, drive in_trig 0 then 1 -> a second identical 100-cycle echo occurs; with in_trig held high and no low phase, no second echo occurs.
REQ-032 in_trig high for 5 cycles then low -> out_echo stays 0 and the FSM returns to IDLE.
REQ-033 DIST_CM=500 -> echo width is 2000 cycles; DIST_CM=1 -> echo width is 2000 cycles.
REQ-034 Toggle in_trig during DELAY/ECHO/COOLDOWN -> echo width is unchanged and no extra echo occurs.
REQ-035 Assert rst during ECHO -> out_echo=0 next cycle; in_trig held high after reset release -> no echo until in_trig goes low and then high.
